alarma_scheduler: RTL and testbench
===================================

# alarma_scheduler

Multi-slot alarm controller that sits between the UART command decoder, the time-of-day counters and the `suna` buzzer/LED driver. It stores four independently enabled alarm times and detects minute boundaries on the time counters. It then schedules exactly one active alarm at a time through a ring/snooze state machine and drives the single `semnal` request that `suna` consumes.

## Interface
Parameters:
- `SNOOZE_MIN`, 10: minutes added per snooze (valid 1..59).
- `MAX_SNOOZE`, 3: snoozes allowed per ring event before the alarm is abandoned.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `minute_counter`  in  6  current minute, 0..59.
- `ore_counter`  in  5  current hour, 0..23.
- `load`  in  1  one-cycle strobe: write the slot selected by `slot_sel`.
- `slot_sel`  in  2  slot index 0..3 for `load`.
- `minute_setare`  in  6  alarm minute to write.
- `ore_setare`  in  5  alarm hour to write.
- `enable_setare`  in  1  enable bit to write; 0 disables the slot.
- `stop`  in  1  dismiss the current alarm (level, sampled each cycle).
- `snooze`  in  1  snooze the current alarm (level, sampled each cycle).
- `semnal`  out  1  ring request to `suna`, registered.
- `slot_activ`  out  2  index of the slot being rung or snoozed; 0 in IDLE.
- `slot_en`  out  4  per-slot enable bits, registered.
- `snoozed`  out  1  high while in SNOOZED.

## Operation
- Storage: 4 slots × {en, hour[4:0], min[5:0]}.
- A `load` with `minute_setare` > 59 or `ore_setare` > 23 is ignored and the slot is unchanged. Otherwise the slot is written on the next edge.
- Minute tick: `prev_min` register. `tick` = (`minute_counter` != `prev_min`). While `reset` is high, `prev_min` loads `minute_counter`, so no tick occurs on the first cycle after reset.
- Match: slot k matches when en=1 and {hour,min} == {`ore_counter`,`minute_counter`}. If several slots match, the lowest index wins.
- FSM states: IDLE, RING, SNOOZED. Registers: `snz_cnt` (2 bits), `tgt_h`/`tgt_m` (snooze target), `act` (active slot).
- IDLE:
  - On `tick` with any match, go to RING with `act` = winning slot and `snz_cnt` = 0.
  - With no match, stay in IDLE.
- RING (`semnal`=1):
  - `stop`: go to IDLE. The slot stays enabled and fires again the next day.
  - `snooze`, or `tick` (one full minute without a response is an automatic snooze):
    - If `snz_cnt` == `MAX_SNOOZE`, go to IDLE.
    - Otherwise go to SNOOZED, set target = now + `SNOOZE_MIN`, and increment `snz_cnt`.
- SNOOZED (`semnal`=0, `snoozed`=1):
  - `tick` with {`ore_counter`,`minute_counter`} == target: go to RING.
  - `stop`: go to IDLE.
  - `snooze`: ignored.
- Target arithmetic, from the counters in the snooze cycle, with m = min + `SNOOZE_MIN`:
  - If m ≥ 60, then tgt_m = m − 60 and hour + 1, where 23 wraps to 0.
  - Otherwise tgt_m = m and the hour is unchanged.
  - The sum is computed 7 bits wide.
- Other slots matching while in RING/SNOOZED are dropped, not queued.
- A `load` to slot `act` while in RING or SNOOZED writes the slot and forces IDLE. A `load` to any other slot does not disturb the FSM.
- Same-cycle priority: `reset` > `stop` > load-to-active > `snooze` > `tick`.

## Timing
- Reset values:
  - `semnal`=0, `slot_activ`=0, `slot_en`=4'b0000, `snoozed`=0.
  - State IDLE; `snz_cnt`=0.
  - Slot times 0:00; targets 0:00.
- `semnal` rises on the edge after the tick cycle in which the match is seen, so latency is 1 clock.
- `stop`/`snooze` asserted in cycle n: `semnal` falls at edge n+1.
- `slot_en` reflects a `load` at the edge that ends the `load` cycle.
- `stop` or `snooze` held for many cycles acts once per state entry. A held `stop` keeps the FSM in IDLE but does not block matches. A match in IDLE with `stop` high enters RING and exits at the next edge.
- A mid-operation reset clears everything on the next edge, with no residual ring.

## Test plan
- Load slot 2 = 07:30 enabled; counters step 07:29→07:30 → `semnal`=1 one clock after the step, `slot_activ`=2; `stop` → `semnal`=0 next clock; the slot is still enabled.
- Slots 1 and 3 both 12:00; step to 12:00 → `slot_activ`=1. Slot 3 never rings during this event.
- Ring at 23:55, `snooze` → SNOOZED with target 00:05; step to 00:05 → RING again, `snz_cnt`=1.
- Ring with no response: each minute tick auto-snoozes. After the 4th ring, the next tick → IDLE, `semnal`=0, with no further ring until the next day.
- Load `minute_setare`=60 to slot 0 → `slot_en[0]` and the slot contents are unchanged. Load to the active slot while SNOOZED → IDLE.
- Assert `reset` during RING → next clock `semnal`=0, `slot_en`=0. Release `reset` with counters static → no tick and no ring.

Source files
------------

// File: rtl/alarma_scheduler.sv
// Four-slot alarm scheduler: minute-tick matching, ring/snooze FSM, single ring request to suna.
// Latency: semnal rises one clock after the tick cycle that matches; stop/snooze take effect at the next edge.
// No backpressure: stop/snooze are level inputs sampled every cycle, and load is a one-cycle strobe.
module alarma_scheduler #(
  parameter int SNOOZE_MIN = 10,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] minute_counter,
  input  logic [4:0] ore_counter,
  input  logic       load,
  input  logic [1:0] slot_sel,
  input  logic [5:0] minute_setare,
  input  logic [4:0] ore_setare,
  input  logic       enable_setare,
  input  logic       stop,
  input  logic       snooze,
  output logic       semnal,
  output logic [1:0] slot_activ,
  output logic [3:0] slot_en,
  output logic       snoozed
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZED} state_t;

  state_t     state, state_nxt;
  logic [5:0] prev_min;
  logic [1:0] snz_cnt, snz_cnt_nxt;
  logic [4:0] tgt_h, tgt_h_nxt;
  logic [5:0] tgt_m, tgt_m_nxt;
  logic [1:0] act, act_nxt;

  logic [3:0] en_r;
  logic [4:0] slot_h [4];
  logic [5:0] slot_m [4];

  logic       tick;
  logic       load_ok;
  logic       load_act;
  logic       hit;
  logic [1:0] hit_idx;
  logic [6:0] m_sum;
  logic [6:0] m_wrap;
  logic       wrap;
  logic [5:0] snz_m;
  logic [4:0] snz_h;

  assign tick     = (minute_counter != prev_min);
  assign load_ok  = (minute_setare <= 6'd59) && (ore_setare <= 5'd23);
  assign load_act = load && load_ok && (slot_sel == act);
  assign slot_en  = en_r;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (en_r[k] && (slot_h[k] == ore_counter) && (slot_m[k] == minute_counter)) begin
        hit     = 1'b1;
        hit_idx = 2'(k);
      end
    end
  end

  always_comb begin
    m_sum  = {1'b0, minute_counter} + 7'(SNOOZE_MIN);
    m_wrap = m_sum - 7'd60;
    wrap   = (m_sum >= 7'd60);
    snz_m  = wrap ? m_wrap[5:0] : m_sum[5:0];
    if (wrap) snz_h = (ore_counter == 5'd23) ? 5'd0 : ore_counter + 5'd1;
    else      snz_h = ore_counter;
  end

  always_comb begin
    state_nxt   = state;
    act_nxt     = act;
    snz_cnt_nxt = snz_cnt;
    tgt_h_nxt   = tgt_h;
    tgt_m_nxt   = tgt_m;
    case (state)
      IDLE: begin
        if (tick && hit) begin
          state_nxt   = RING;
          act_nxt     = hit_idx;
          snz_cnt_nxt = 2'd0;
        end
      end
      RING: begin
        if (stop || load_act) begin
          state_nxt = IDLE;
        end else if (snooze || tick) begin
          // An unanswered minute counts as a snooze.
          if (snz_cnt == 2'(MAX_SNOOZE)) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = SNOOZED;
            tgt_h_nxt   = snz_h;
            tgt_m_nxt   = snz_m;
            snz_cnt_nxt = snz_cnt + 2'd1;
          end
        end
      end
      SNOOZED: begin
        if (stop || load_act) begin
          state_nxt = IDLE;
        end else if (tick && (ore_counter == tgt_h) && (minute_counter == tgt_m)) begin
          state_nxt = RING;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // prev_min tracks the counter even during reset so release causes no spurious tick.
  always_ff @(posedge clock) begin
    prev_min <= minute_counter;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      act        <= 2'd0;
      snz_cnt    <= 2'd0;
      tgt_h      <= 5'd0;
      tgt_m      <= 6'd0;
      en_r       <= 4'b0000;
      semnal     <= 1'b0;
      slot_activ <= 2'd0;
      snoozed    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        slot_h[k] <= 5'd0;
        slot_m[k] <= 6'd0;
      end
    end else begin
      state      <= state_nxt;
      act        <= act_nxt;
      snz_cnt    <= snz_cnt_nxt;
      tgt_h      <= tgt_h_nxt;
      tgt_m      <= tgt_m_nxt;
      semnal     <= (state_nxt == RING);
      snoozed    <= (state_nxt == SNOOZED);
      slot_activ <= (state_nxt == IDLE) ? 2'd0 : act_nxt;
      if (load && load_ok) begin
        en_r[slot_sel]   <= enable_setare;
        slot_h[slot_sel] <= ore_setare;
        slot_m[slot_sel] <= minute_setare;
      end
    end
  end

endmodule

// File: tb/tb_alarma_scheduler.sv
// Directed bench for alarma_scheduler; expected outputs are queued per step and compared after the edge.
module tb_alarma_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] minute_counter = 6'd0;
  logic [4:0] ore_counter = 5'd0;
  logic       load = 1'b0;
  logic [1:0] slot_sel = 2'd0;
  logic [5:0] minute_setare = 6'd0;
  logic [4:0] ore_setare = 5'd0;
  logic       enable_setare = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       semnal;
  logic [1:0] slot_activ;
  logic [3:0] slot_en;
  logic       snoozed;

  string      tag_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  alarma_scheduler #(.SNOOZE_MIN(10), .MAX_SNOOZE(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .minute_counter (minute_counter),
    .ore_counter    (ore_counter),
    .load           (load),
    .slot_sel       (slot_sel),
    .minute_setare  (minute_setare),
    .ore_setare     (ore_setare),
    .enable_setare  (enable_setare),
    .stop           (stop),
    .snooze         (snooze),
    .semnal         (semnal),
    .slot_activ     (slot_activ),
    .slot_en        (slot_en),
    .snoozed        (snoozed)
  );

  // Queue the expected {semnal, slot_activ, slot_en, snoozed} after the next edge, then clock and compare.
  task automatic step(input string tag, input logic s, input logic [1:0] a,
                      input logic [3:0] en, input logic z);
    string      t;
    logic [7:0] e;
    logic [7:0] obs;
    tag_q.push_back(tag);
    exp_q.push_back({s, a, en, z});
    @(posedge clock);
    #1;
    while (exp_q.size() > 0) begin
      t   = tag_q.pop_front();
      e   = exp_q.pop_front();
      obs = {semnal, slot_activ, slot_en, snoozed};
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b (semnal,slot_activ,slot_en,snoozed)", t, obs, e);
      end
    end
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m);
    ore_counter    = h;
    minute_counter = m;
  endtask

  task automatic do_load(input logic [1:0] slot, input logic [4:0] h, input logic [5:0] m,
                         input logic en, input string tag, input logic s, input logic [1:0] a,
                         input logic [3:0] en_exp, input logic z);
    load          = 1'b1;
    slot_sel      = slot;
    ore_setare    = h;
    minute_setare = m;
    enable_setare = en;
    step(tag, s, a, en_exp, z);
    load = 1'b0;
  endtask

  initial begin
    set_time(5'd7, 6'd29);
    step("rst0", 0, 2'd0, 4'b0000, 0);
    step("rst1", 0, 2'd0, 4'b0000, 0);
    reset = 1'b0;
    step("idle_after_rst", 0, 2'd0, 4'b0000, 0);

    // Basic ring and stop on slot 2.
    do_load(2'd2, 5'd7, 6'd30, 1'b1, "load_s2", 0, 2'd0, 4'b0100, 0);
    set_time(5'd7, 6'd30);
    step("ring_s2", 1, 2'd2, 4'b0100, 0);
    step("ring_s2_hold", 1, 2'd2, 4'b0100, 0);
    stop = 1'b1;
    step("stop_s2", 0, 2'd0, 4'b0100, 0);
    step("stop_s2_held", 0, 2'd0, 4'b0100, 0);
    stop = 1'b0;

    // Two slots match at once: lowest index wins, the other is dropped.
    do_load(2'd1, 5'd12, 6'd0, 1'b1, "load_s1", 0, 2'd0, 4'b0110, 0);
    do_load(2'd3, 5'd12, 6'd0, 1'b1, "load_s3", 0, 2'd0, 4'b1110, 0);
    set_time(5'd11, 6'd59);
    step("pre_noon", 0, 2'd0, 4'b1110, 0);
    set_time(5'd12, 6'd0);
    step("noon_lowest", 1, 2'd1, 4'b1110, 0);
    stop = 1'b1;
    step("noon_stop", 0, 2'd0, 4'b1110, 0);
    stop = 1'b0;
    step("noon_no_s3", 0, 2'd0, 4'b1110, 0);

    // Midnight-wrapping snooze, then unanswered rings until abandon.
    do_load(2'd3, 5'd23, 6'd55, 1'b1, "load_s3_late", 0, 2'd0, 4'b1110, 0);
    set_time(5'd23, 6'd54);
    step("pre_late", 0, 2'd0, 4'b1110, 0);
    set_time(5'd23, 6'd55);
    step("ring_late", 1, 2'd3, 4'b1110, 0);
    snooze = 1'b1;
    step("snooze_late", 0, 2'd3, 4'b1110, 1);
    step("snooze_held", 0, 2'd3, 4'b1110, 1);
    snooze = 1'b0;
    set_time(5'd0, 6'd4);
    step("not_target", 0, 2'd3, 4'b1110, 1);
    set_time(5'd0, 6'd5);
    step("ring2_wrap", 1, 2'd3, 4'b1110, 0);
    set_time(5'd0, 6'd6);
    step("auto_snz1", 0, 2'd3, 4'b1110, 1);
    set_time(5'd0, 6'd15);
    step("wait_016", 0, 2'd3, 4'b1110, 1);
    set_time(5'd0, 6'd16);
    step("ring3", 1, 2'd3, 4'b1110, 0);
    set_time(5'd0, 6'd17);
    step("auto_snz2", 0, 2'd3, 4'b1110, 1);
    set_time(5'd0, 6'd27);
    step("ring4", 1, 2'd3, 4'b1110, 0);
    step("ring4_hold", 1, 2'd3, 4'b1110, 0);
    set_time(5'd0, 6'd28);
    step("abandon", 0, 2'd0, 4'b1110, 0);
    set_time(5'd0, 6'd38);
    step("no_more_ring", 0, 2'd0, 4'b1110, 0);

    // Out-of-range loads are ignored; slot contents survive.
    do_load(2'd0, 5'd5, 6'd10, 1'b1, "load_s0", 0, 2'd0, 4'b1111, 0);
    do_load(2'd0, 5'd6, 6'd60, 1'b0, "bad_min", 0, 2'd0, 4'b1111, 0);
    do_load(2'd0, 5'd24, 6'd10, 1'b0, "bad_hour", 0, 2'd0, 4'b1111, 0);
    set_time(5'd5, 6'd9);
    step("pre_s0", 0, 2'd0, 4'b1111, 0);
    set_time(5'd5, 6'd10);
    step("ring_s0_kept", 1, 2'd0, 4'b1111, 0);
    snooze = 1'b1;
    step("snooze_s0", 0, 2'd0, 4'b1111, 1);
    snooze = 1'b0;
    do_load(2'd1, 5'd12, 6'd0, 1'b1, "load_other", 0, 2'd0, 4'b1111, 1);
    do_load(2'd0, 5'd5, 6'd10, 1'b1, "load_active", 0, 2'd0, 4'b1111, 0);
    set_time(5'd5, 6'd20);
    step("old_target", 0, 2'd0, 4'b1111, 0);

    // A held stop does not block a match; the ring lasts one clock.
    stop = 1'b1;
    set_time(5'd7, 6'd29);
    step("stop_idle", 0, 2'd0, 4'b1111, 0);
    set_time(5'd7, 6'd30);
    step("stop_held_match", 1, 2'd2, 4'b1111, 0);
    step("stop_held_exit", 0, 2'd0, 4'b1111, 0);
    stop = 1'b0;

    // Reset in the middle of a ring.
    set_time(5'd7, 6'd31);
    step("pre_rering", 0, 2'd0, 4'b1111, 0);
    set_time(5'd7, 6'd30);
    step("rering", 1, 2'd2, 4'b1111, 0);
    reset = 1'b1;
    step("rst_mid", 0, 2'd0, 4'b0000, 0);
    set_time(5'd7, 6'd31);
    step("rst_mid_hold", 0, 2'd0, 4'b0000, 0);
    reset = 1'b0;
    step("rel_static", 0, 2'd0, 4'b0000, 0);
    do_load(2'd2, 5'd7, 6'd31, 1'b1, "load_no_tick", 0, 2'd0, 4'b0100, 0);
    step("no_tick_ring", 0, 2'd0, 4'b0100, 0);
    set_time(5'd7, 6'd32);
    step("next_min", 0, 2'd0, 4'b0100, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
